voter_session_ctrl: RTL and testbench



---
 rtl/voter_pkg.sv | 19 +
 rtl/voter_eval.sv | 29 ++
 rtl/voter_session_ctrl.sv | 129 ++++++++++++
 tb/tb_voter_session_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// Shared types and constants for the 4-voter majority ballot controller.
package voter_pkg;

  localparam int unsigned N_VOTERS = 4;
  localparam int unsigned RES_W    = 3;

  // 1-based result positions: result[RES_x-1] is the flag for that outcome.
  localparam int unsigned RES_YES = 3;
  localparam int unsigned RES_TIE = 2;
  localparam int unsigned RES_NO  = 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL,
    DONE
  } state_e;

endpackage

// File: rtl/voter_eval.sv
// Combinational ballot evaluator: counts yes votes and returns a one-hot
// yes-majority / tie / no-majority flag.
module voter_eval
  import voter_pkg::*;
(
  input  logic [N_VOTERS-1:0] ballot,
  output logic [RES_W-1:0]    result_c
);

  localparam int unsigned CNT_W = 3;

  logic [CNT_W-1:0] yes_cnt;

  always_comb begin
    yes_cnt  = '0;
    result_c = '0;
    for (int i = 0; i < int'(N_VOTERS); i++) begin
      yes_cnt = yes_cnt + CNT_W'(ballot[i]);
    end
    if (yes_cnt >= CNT_W'(3)) begin
      result_c[RES_YES-1] = 1'b1;
    end else if (yes_cnt == CNT_W'(2)) begin
      result_c[RES_TIE-1] = 1'b1;
    end else begin
      result_c[RES_NO-1] = 1'b1;
    end
  end

endmodule

// File: rtl/voter_session_ctrl.sv
// Ballot round sequencer: IDLE -> COLLECT -> EVAL -> DONE with vote timeout.
// Define VOTER_REVOTE_EN for last-vote-wins and fixed-length sessions.
module voter_session_ctrl
  import voter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted_mask,
  output logic                done,
  output logic                timed_out,
  output logic [RES_W-1:0]    result
);

  localparam int unsigned TIMER_W = 8;

  state_e              state_q, state_d;
  logic [N_VOTERS-1:0] ballot_q, ballot_d;
  logic [N_VOTERS-1:0] mask_q, mask_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                timed_out_q, timed_out_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [RES_W-1:0]    eval_res_c;
  logic                at_limit;
`ifndef VOTER_REVOTE_EN
  logic [N_VOTERS-1:0] accept;
`endif

  voter_eval u_eval (
    .ballot   (ballot_q),
    .result_c (eval_res_c)
  );

  always_comb begin
    state_d     = state_q;
    ballot_d    = ballot_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    timed_out_d = timed_out_q;
    result_d    = result_q;
    at_limit    = (timer_q == TIMER_W'(TIMEOUT - 1));
`ifndef VOTER_REVOTE_EN
    accept      = '0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = COLLECT;
          ballot_d    = '0;
          mask_d      = '0;
          timer_d     = '0;
          timed_out_d = 1'b0;
        end
      end
      COLLECT: begin
        timer_d = timer_q + TIMER_W'(1);
`ifdef VOTER_REVOTE_EN
        ballot_d = (ballot_q & ~vote_valid) | (vote_val & vote_valid);
        mask_d   = mask_q | vote_valid;
        if (at_limit) begin
          state_d     = EVAL;
          timed_out_d = 1'b1;
        end
`else
        // Only voters without a recorded vote are accepted: first vote wins.
        accept   = vote_valid & ~mask_q;
        ballot_d = (ballot_q & ~accept) | (vote_val & accept);
        mask_d   = mask_q | accept;
        if (&mask_d) begin
          state_d = EVAL;
        end else if (at_limit) begin
          state_d     = EVAL;
          timed_out_d = 1'b1;
        end
`endif
      end
      EVAL: begin
        result_d = eval_res_c;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == COLLECT) || (state_d == EVAL);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ballot_q    <= '0;
      mask_q      <= '0;
      timer_q     <= '0;
      timed_out_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ballot_q    <= ballot_d;
      mask_q      <= mask_d;
      timer_q     <= timer_d;
      timed_out_q <= timed_out_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy       = busy_q;
  assign voted_mask = mask_q;
  assign done       = done_q;
  assign timed_out  = timed_out_q;
  assign result     = result_q;

endmodule

// File: tb/tb_voter_session_ctrl.sv
// Directed bench for voter_session_ctrl (TIMEOUT = 16).
module tb_voter_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic       busy;
  logic [3:0] voted_mask;
  logic       done;
  logic       timed_out;
  logic [2:0] result;

  int checks = 0;
  int errors = 0;
  int done_cnt;

  voter_session_ctrl #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vote_valid (vote_valid),
    .vote_val   (vote_val),
    .busy       (busy),
    .voted_mask (voted_mask),
    .done       (done),
    .timed_out  (timed_out),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    vote_valid = 4'b0000;
    vote_val   = 4'b0000;
    tick();
    tick();
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_mask", 8'(voted_mask), 8'h0);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_tmo", 8'(timed_out), 8'h0);
    chk("rst_result", 8'(result), 8'h0);
    rst_n = 1'b1;
    tick();

`ifdef VOTER_REVOTE_EN
    // Voter 2 revotes 0 -> 1; session runs full length despite full mask.
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b1111; vote_val = 4'b0011;
    tick();
    vote_valid = 4'b0100; vote_val = 4'b0100;
    tick();
    vote_valid = 4'b0000; vote_val = 4'b0000;
    chk("rv_busy_c3", 8'(busy), 8'h1);
    chk("rv_mask_c3", 8'(voted_mask), 8'hf);
    done_cnt = 0;
    for (int n = 3; n <= 17; n++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("rv_no_early_done", 8'(done_cnt), 8'h0);
    chk("rv_done", 8'(done), 8'h1);
    chk("rv_tmo", 8'(timed_out), 8'h1);
    chk("rv_result", 8'(result), 8'h4);
    tick();
`else
    // All four votes in one cycle.
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b1111; vote_val = 4'b1011;
    chk("t1_busy_collect", 8'(busy), 8'h1);
    tick();
    vote_valid = 4'b0000; vote_val = 4'b0000;
    chk("t1_busy_eval", 8'(busy), 8'h1);
    chk("t1_mask", 8'(voted_mask), 8'hf);
    chk("t1_done_eval", 8'(done), 8'h0);
    tick();
    chk("t1_done", 8'(done), 8'h1);
    chk("t1_result", 8'(result), 8'h4);
    chk("t1_tmo", 8'(timed_out), 8'h0);
    chk("t1_busy_done", 8'(busy), 8'h0);
    tick();
    chk("t1_done_drop", 8'(done), 8'h0);
    chk("t1_result_hold", 8'(result), 8'h4);

    // Staggered votes, voter 1 re-votes (ignored), stray start while busy.
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b0001; vote_val = 4'b0001;
    tick();
    vote_valid = 4'b0010; vote_val = 4'b0000;
    tick();
    vote_valid = 4'b0010; vote_val = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_mask_c3", 8'(voted_mask), 8'h3);
    vote_valid = 4'b0110; vote_val = 4'b0110;
    tick();
    chk("t2_mask_c4", 8'(voted_mask), 8'h7);
    chk("t2_busy_c4", 8'(busy), 8'h1);
    vote_valid = 4'b1000; vote_val = 4'b0000;
    tick();
    vote_valid = 4'b0000; vote_val = 4'b0000;
    tick();
    chk("t2_done", 8'(done), 8'h1);
    chk("t2_result", 8'(result), 8'h2);
    chk("t2_tmo", 8'(timed_out), 8'h0);
    tick();

    // Timeout with only voters 0 and 1 voting yes.
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b0011; vote_val = 4'b0011;
    tick();
    vote_valid = 4'b0000; vote_val = 4'b0000;
    done_cnt = 0;
    for (int n = 2; n <= 17; n++) begin
      if (done) done_cnt++;
      if (n == 17) chk("t3_busy_c17", 8'(busy), 8'h1);
      tick();
    end
    chk("t3_no_early_done", 8'(done_cnt), 8'h0);
    chk("t3_done_c18", 8'(done), 8'h1);
    chk("t3_tmo", 8'(timed_out), 8'h1);
    chk("t3_result", 8'(result), 8'h2);
    chk("t3_mask", 8'(voted_mask), 8'h3);
    tick();

    // Last vote lands on the timer's final cycle: completion wins.
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b0111; vote_val = 4'b0011;
    tick();
    vote_valid = 4'b0000; vote_val = 4'b0000;
    for (int n = 2; n <= 15; n++) tick();
    chk("t4_mask_c16", 8'(voted_mask), 8'h7);
    chk("t4_busy_c16", 8'(busy), 8'h1);
    vote_valid = 4'b1000; vote_val = 4'b1000;
    tick();
    vote_valid = 4'b0000; vote_val = 4'b0000;
    chk("t4_tmo_eval", 8'(timed_out), 8'h0);
    tick();
    chk("t4_done", 8'(done), 8'h1);
    chk("t4_result", 8'(result), 8'h4);
    chk("t4_tmo", 8'(timed_out), 8'h0);
    tick();
`endif

    // Asynchronous reset in the middle of COLLECT.
    start = 1'b1;
    tick();
    start = 1'b0; vote_valid = 4'b0001; vote_val = 4'b0001;
    tick();
    vote_valid = 4'b0000; vote_val = 4'b0000;
    chk("t5_mask_pre", 8'(voted_mask), 8'h1);
    chk("t5_busy_pre", 8'(busy), 8'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", 8'(busy), 8'h0);
    chk("t5_mask_rst", 8'(voted_mask), 8'h0);
    chk("t5_done_rst", 8'(done), 8'h0);
    chk("t5_result_rst", 8'(result), 8'h0);
    #3;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("t5_no_done", 8'(done_cnt), 8'h0);
    chk("t5_busy_after", 8'(busy), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
